mpc_vector_feeder: RTL and testbench
====================================

# mpc_vector_feeder

Controller-side counterpart of the matrix-converter switching block. It holds switching commands (vector code plus per-phase commutation direction) written by the MPC processor. On each control-period interrupt from the switching block it presents the next command on `v`/`dir`. It forces the switching block into clamp when the processor repeatedly fails to supply commands in time.

## Interface
Parameters:
- `DEPTH`, 16: command FIFO entries; power of two, at least 2.
- `MAX_VEC`, 26: highest legal vector code; codes above it are illegal.
- `MISS_LIMIT`, 3: consecutive empty-FIFO periods that trigger clamp; range 1..255.

Ports:
- `clk`, in, 1: system clock, 10 ns.
- `rst`, in, 1: reset, synchronous, active-high.
- `wr_valid`, in, 1: processor offers a command.
- `wr_ready`, out, 1: feeder accepts the command; a transfer occurs when `wr_valid & wr_ready` at a `clk` edge.
- `wr_vec`, in, 5: vector code.
- `wr_dir`, in, 3: commutation direction, one bit per output phase.
- `interrupt`, in, 1: period toggle from the switching block; each rising edge starts a new control period.
- `v`, out, 5: current vector code to the switching block.
- `dir`, out, 3: current direction to the switching block.
- `clamp_signal`, out, 1: clamp request to the switching block; sticky.
- `fill`, out, log2(DEPTH)+1: number of entries held in the FIFO.
- `underflow_cnt`, out, 16: total count of empty periods; saturates at 0xFFFF.
- `err_illegal`, out, 1: one-cycle pulse when an illegal code is written.

## Operation
- Reset values:
  - `v` = 0, the zero vector.
  - `dir` = 0.
  - `clamp_signal` = 0.
  - `fill` = 0.
  - `underflow_cnt` = 0.
  - `err_illegal` = 0.
  - Miss counter = 0.
  - FSM = RUN.
  - FIFO pointers are cleared.
  - `interrupt` sync flops are cleared to 0.
- Write path:
  - `wr_ready` = (`fill` < DEPTH) and FSM == RUN. The value is computed from the registered `fill`, so a pop in the same cycle does not raise it.
  - If the accepted `wr_vec` > MAX_VEC, the command is consumed but not stored, and `err_illegal` pulses on the next cycle.
- Period boundary:
  - `interrupt` passes through 2 sync flops plus 1 edge-detect flop.
  - A one-cycle `tick` is produced per rising edge. Falling edges are ignored.
- On `tick` in RUN:
  - FIFO non-empty: pop the head into `v`/`dir` and clear the miss counter.
  - FIFO empty: hold `v`/`dir`, increment `underflow_cnt` (saturating), and increment the miss counter. If the new miss count == MISS_LIMIT, go to CLAMP.
- CLAMP state:
  - `clamp_signal` = 1, `v` = 0, `dir` = 0.
  - The FIFO is flushed (`fill` = 0) and writes are refused.
  - Ticks still increment `underflow_cnt`.
  - The only exit is `rst`.
- Simultaneous write and tick with an empty FIFO: the write is stored, and the tick counts as a miss. The command is used at the next tick.
- Simultaneous write and pop with `fill` = DEPTH: the write is refused because `wr_ready` = 0.
- Reset mid-operation clears everything. A pending sync edge is discarded.

## Timing
- Let E0 be the first `clk` edge that samples `interrupt` = 1.
- `tick` is high in the cycle after E2. The `v`/`dir` update, the `underflow_cnt` increment and the CLAMP entry take effect at E3.
- `clamp_signal` is registered and rises at the same edge E3.
- `fill` is registered and reflects a push or pop at the edge where it occurs.
- Sustained throughput is one write per cycle. Tick spacing is ≥ 4 µs, so ticks never overlap.

## Structure
- Shared package `dmc_pkg`:
  - `VEC_W` = 5, `DIR_W` = 3.
  - `ZERO_VEC` = 5'd0, `MAX_VEC_DEFAULT` = 26.
  - Command typedef: `{vec, dir}`, 8 bits.
  - FSM state enum: RUN, CLAMP.
- Sub-module `cmd_fifo`:
  - Synchronous FIFO, parameterised DEPTH, 8-bit entries.
  - Ports: push, pop, flush, head data, count.
  - Pop on empty has no effect.
- Top level holds the synchroniser, edge detect, FSM, miss counter, underflow counter and output registers.

## Test plan
- Reset, then write (3, 3'b101) and (7, 3'b010), then two `interrupt` rising edges → `v`/`dir` = 3/101 at E3 of the first edge, then 7/010; `fill` goes 2 → 1 → 0.
- Write DEPTH commands → `wr_ready` = 0 and `fill` = 16. A 17th write is not accepted; after one tick, `wr_ready` = 1 again.
- Write `wr_vec` = 27 → `err_illegal` pulses once, `fill` is unchanged, and the next tick shows no change to `v`.
- Empty FIFO for 2 ticks, then one write, then a tick → `underflow_cnt` = 2, the miss counter clears, and `clamp_signal` stays 0.
- Empty FIFO for 3 ticks with `v` = 9 beforehand → `clamp_signal` = 1 and `v` = 0 at E3 of the third tick. Later writes are refused, and only `rst` clears the clamp.
- Assert `rst` one cycle after E1 of an `interrupt` edge → no tick occurs, and all outputs hold their reset values.

Source files
------------

// File: rtl/dmc_pkg.sv
// Shared types and constants for the MPC-side matrix-converter command path.
package dmc_pkg;

  localparam int unsigned VEC_W = 5;
  localparam int unsigned DIR_W = 3;
  localparam logic [VEC_W-1:0] ZERO_VEC = 5'd0;
  localparam int unsigned MAX_VEC_DEFAULT = 26;

  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic [DIR_W-1:0] dir;
  } cmd_t;

  typedef enum logic {
    StRun,
    StClamp
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with flush; push when full and pop when empty are ignored.
module cmd_fifo
  import dmc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  cmd_t          push_data,
  input  logic          pop,
  input  logic          flush,
  output cmd_t          head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] Full = CW'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push && (count_q != Full);
    do_pop  = pop && (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/mpc_vector_feeder.sv
// Feeds buffered MPC switching commands to the switching block once per control period,
// falling back to a sticky clamp when the processor keeps missing periods.
module mpc_vector_feeder
  import dmc_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_VEC    = MAX_VEC_DEFAULT,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [VEC_W-1:0]         wr_vec,
  input  logic [DIR_W-1:0]         wr_dir,
  input  logic                     interrupt,
  output logic [VEC_W-1:0]         v,
  output logic [DIR_W-1:0]         dir,
  output logic                     clamp_signal,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [15:0]              underflow_cnt,
  output logic                     err_illegal
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    Full    = CW'(DEPTH);
  localparam logic [VEC_W-1:0] MaxV    = VEC_W'(MAX_VEC);
  localparam logic [7:0]       MissLim = 8'(MISS_LIMIT);

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              edge_q, tick_q;
  logic [7:0]        miss_q, miss_inc;
  logic [15:0]       under_q;
  logic [VEC_W-1:0]  v_q;
  logic [DIR_W-1:0]  dir_q;
  logic              err_q;
  logic              wr_accept, illegal, push, pop, flush, fifo_empty;
  cmd_t              head;
  logic [CW-1:0]     count;

  // Two-flop synchroniser, then a registered rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], interrupt};
      edge_q <= sync_q[1];
      tick_q <= sync_q[1] & ~edge_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  always_comb begin
    miss_inc   = miss_q + 8'd1;
    fifo_empty = (count == '0);
    state_d    = state_q;
    unique case (state_q)
      StRun:   if (tick_q && fifo_empty && (miss_inc == MissLim)) state_d = StClamp;
      StClamp: state_d = StClamp;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    wr_ready     = (state_q == StRun) && (count < Full);
    clamp_signal = (state_q == StClamp);
    pop          = (state_q == StRun) && tick_q && !fifo_empty;
    flush        = (state_d == StClamp);
    wr_accept    = wr_valid && wr_ready;
    illegal      = (wr_vec > MaxV);
    push         = wr_accept && !illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_q  <= '0;
      under_q <= '0;
      v_q     <= ZERO_VEC;
      dir_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= wr_accept && illegal;
      // In clamp the FIFO is held flushed, so every tick is an empty period.
      if (tick_q && (fifo_empty || state_q == StClamp) && (under_q != 16'hFFFF)) begin
        under_q <= under_q + 16'd1;
      end
      if (pop) begin
        miss_q <= '0;
      end else if (tick_q && fifo_empty && state_q == StRun) begin
        miss_q <= miss_inc;
      end
      if (state_d == StClamp) begin
        v_q   <= ZERO_VEC;
        dir_q <= '0;
      end else if (pop) begin
        v_q   <= head.vec;
        dir_q <= head.dir;
      end
    end
  end

  cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({wr_vec, wr_dir}),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .count    (count)
  );

  assign v             = v_q;
  assign dir           = dir_q;
  assign fill          = count;
  assign underflow_cnt = under_q;
  assign err_illegal   = err_q;

endmodule

// File: tb/tb_mpc_vector_feeder.sv
// Bench for mpc_vector_feeder: directed scenarios plus randomized traffic against a queue model.
module tb_mpc_vector_feeder;

  localparam int DEPTH = 16;
  localparam int MAXV  = 26;
  localparam int MLIM  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [4:0] wr_vec = '0;
  logic [2:0] wr_dir = '0;
  logic       interrupt = 1'b0;
  logic [4:0] v;
  logic [2:0] dir;
  logic       clamp_signal;
  logic [4:0] fill;
  logic [15:0] underflow_cnt;
  logic       err_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  mpc_vector_feeder #(
    .DEPTH     (DEPTH),
    .MAX_VEC   (MAXV),
    .MISS_LIMIT(MLIM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_vec       (wr_vec),
    .wr_dir       (wr_dir),
    .interrupt    (interrupt),
    .v            (v),
    .dir          (dir),
    .clamp_signal (clamp_signal),
    .fill         (fill),
    .underflow_cnt(underflow_cnt),
    .err_illegal  (err_illegal)
  );

  always #5 clk = ~clk;

  // Reference model: a command queue, period actions 3 edges after interrupt is first seen high.
  logic [7:0] m_q[$];
  logic [4:0] m_v = '0;
  logic [2:0] m_dir = '0;
  logic       m_clamp = 1'b0;
  logic       m_err = 1'b0;
  int         m_under = 0;
  int         m_miss = 0;
  logic       hist[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic       m_tick, m_acc;
  logic [7:0] m_c;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_v = '0; m_dir = '0; m_clamp = 1'b0; m_err = 1'b0; m_under = 0; m_miss = 0;
      for (int i = 0; i < 4; i++) hist[i] = 1'b0;
    end else begin
      m_tick = hist[2] && !hist[3];
      m_acc  = wr_valid && !m_clamp && (m_q.size() < DEPTH);
      if (m_tick) begin
        if (m_clamp) begin
          if (m_under < 65535) m_under++;
        end else if (m_q.size() > 0) begin
          m_c = m_q.pop_front();
          m_v = m_c[7:3]; m_dir = m_c[2:0]; m_miss = 0;
        end else begin
          if (m_under < 65535) m_under++;
          m_miss++;
          if (m_miss == MLIM) begin
            m_clamp = 1'b1; m_v = '0; m_dir = '0; m_q.delete();
          end
        end
      end
      m_err = m_acc && (int'(wr_vec) > MAXV);
      if (m_acc && int'(wr_vec) <= MAXV && !m_clamp) m_q.push_back({wr_vec, wr_dir});
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = interrupt;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; interrupt = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic push(input logic [4:0] vec, input logic [2:0] d);
    wr_valid = 1'b1; wr_vec = vec; wr_dir = d;
    cyc(1);
    wr_valid = 1'b0;
  endtask

  // Returns one cycle after E3, so outputs show the period's update.
  task automatic tick_edge();
    interrupt = 1'b1;
    cyc(4);
    interrupt = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; interrupt = 1'b0;
    cyc(2);
    n_tests++;
    if ({v, dir, clamp_signal, fill, underflow_cnt, err_illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: v=%0d dir=%b clamp=%b fill=%0d under=%0d err=%b required all 0",
               v, dir, clamp_signal, fill, underflow_cnt, err_illegal);
    end
    rst = 1'b0;
    cyc(1);
    n_tests++;
    if (wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: wr_ready=%b required 1", wr_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    push(5'd3, 3'b101);
    push(5'd7, 3'b010);
    n_tests++;
    if (fill !== 5'd2) begin n_fail++; $display("FAIL basic_fill2: fill=%0d required 2", fill); end
    interrupt = 1'b1;
    cyc(3);
    n_tests++;
    if (v !== 5'd0) begin n_fail++; $display("FAIL basic_latency: v=%0d after E2 required 0", v); end
    cyc(1);
    n_tests++;
    if (v !== 5'd3 || dir !== 3'b101 || fill !== 5'd1) begin
      n_fail++; $display("FAIL basic_first: v=%0d dir=%b fill=%0d required 3 101 1", v, dir, fill);
    end
    interrupt = 1'b0;
    cyc(1);
    tick_edge();
    n_tests++;
    if (v !== 5'd7 || dir !== 3'b010 || fill !== 5'd0) begin
      n_fail++; $display("FAIL basic_second: v=%0d dir=%b fill=%0d required 7 010 0", v, dir, fill);
    end
  endtask

  task automatic test_full();
    logic [4:0] first_vec;
    do_reset();
    first_vec = 5'($urandom_range(0, MAXV));
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_vec   = (i == 0) ? first_vec : 5'($urandom_range(0, MAXV));
      wr_dir   = 3'($urandom_range(0, 7));
      cyc(1);
    end
    n_tests++;
    if (fill !== 5'd16 || wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_level: fill=%0d ready=%b required 16 0", fill, wr_ready);
    end
    wr_vec = 5'd1;
    cyc(2);
    n_tests++;
    if (fill !== 5'd16) begin n_fail++; $display("FAIL full_17th: fill=%0d required 16", fill); end
    wr_valid = 1'b0;
    tick_edge();
    n_tests++;
    if (fill !== 5'd15 || wr_ready !== 1'b1 || v !== first_vec) begin
      n_fail++;
      $display("FAIL full_after_tick: fill=%0d ready=%b v=%0d required 15 1 %0d",
               fill, wr_ready, v, first_vec);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    push(5'd5, 3'b011);
    tick_edge();
    push(5'd27, 3'b111);
    n_tests++;
    if (err_illegal !== 1'b1 || fill !== 5'd0) begin
      n_fail++; $display("FAIL illegal_pulse: err=%b fill=%0d required 1 0", err_illegal, fill);
    end
    cyc(1);
    n_tests++;
    if (err_illegal !== 1'b0) begin
      n_fail++; $display("FAIL illegal_once: err=%b required 0", err_illegal);
    end
    tick_edge();
    n_tests++;
    if (v !== 5'd5 || dir !== 3'b011 || underflow_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL illegal_hold: v=%0d dir=%b under=%0d required 5 011 1", v, dir, underflow_cnt);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    tick_edge();
    tick_edge();
    n_tests++;
    if (underflow_cnt !== 16'd2 || clamp_signal !== 1'b0) begin
      n_fail++;
      $display("FAIL under_two: under=%0d clamp=%b required 2 0", underflow_cnt, clamp_signal);
    end
    push(5'd12, 3'b110);
    tick_edge();
    n_tests++;
    if (v !== 5'd12 || underflow_cnt !== 16'd2 || clamp_signal !== 1'b0) begin
      n_fail++;
      $display("FAIL under_recover: v=%0d under=%0d clamp=%b required 12 2 0",
               v, underflow_cnt, clamp_signal);
    end
    tick_edge();
    tick_edge();
    n_tests++;
    if (clamp_signal !== 1'b0 || underflow_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL under_miss_clear: clamp=%b under=%0d required 0 4", clamp_signal, underflow_cnt);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    push(5'd9, 3'b001);
    tick_edge();
    tick_edge();
    tick_edge();
    n_tests++;
    if (clamp_signal !== 1'b0 || v !== 5'd9) begin
      n_fail++; $display("FAIL clamp_early: clamp=%b v=%0d required 0 9", clamp_signal, v);
    end
    interrupt = 1'b1;
    cyc(3);
    n_tests++;
    if (clamp_signal !== 1'b0) begin
      n_fail++; $display("FAIL clamp_latency: clamp=%b after E2 required 0", clamp_signal);
    end
    cyc(1);
    n_tests++;
    if (clamp_signal !== 1'b1 || v !== 5'd0 || dir !== 3'b000 || underflow_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL clamp_entry: clamp=%b v=%0d dir=%b under=%0d required 1 0 000 3",
               clamp_signal, v, dir, underflow_cnt);
    end
    interrupt = 1'b0;
    cyc(1);
    n_tests++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL clamp_ready: ready=%b required 0", wr_ready); end
    push(5'd4, 3'b100);
    tick_edge();
    n_tests++;
    if (fill !== 5'd0 || underflow_cnt !== 16'd4 || clamp_signal !== 1'b1 || v !== 5'd0) begin
      n_fail++;
      $display("FAIL clamp_hold: fill=%0d under=%0d clamp=%b v=%0d required 0 4 1 0",
               fill, underflow_cnt, clamp_signal, v);
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    n_tests++;
    if (clamp_signal !== 1'b0 || wr_ready !== 1'b1 || underflow_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL clamp_exit: clamp=%b ready=%b under=%0d required 0 1 0",
               clamp_signal, wr_ready, underflow_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(5'd4, 3'b110);
    push(5'd8, 3'b001);
    push(5'd2, 3'b010);
    tick_edge();
    interrupt = 1'b1;
    cyc(2);
    rst = 1'b1; interrupt = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(6);
    n_tests++;
    if ({v, dir, clamp_signal, fill, underflow_cnt, err_illegal} !== '0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: v=%0d dir=%b clamp=%b fill=%0d under=%0d err=%b ready=%b required 0s, ready 1",
               v, dir, clamp_signal, fill, underflow_cnt, err_illegal, wr_ready);
    end
  endtask

  task automatic test_random();
    int wr_pct[4] = '{60, 5, 30, 2};
    int gap;
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      gap = $urandom_range(4, 14);
      for (int c = 0; c < 800; c++) begin
        n_tests++;
        if (v !== m_v || dir !== m_dir || clamp_signal !== m_clamp || int'(fill) != m_q.size() ||
            int'(underflow_cnt) != m_under || err_illegal !== m_err ||
            wr_ready !== (!m_clamp && m_q.size() < DEPTH)) begin
          n_fail++;
          $display("FAIL rand_p%0d_c%0d: v=%0d dir=%b clamp=%b fill=%0d under=%0d err=%b ready=%b required %0d %b %b %0d %0d %b %b",
                   ph, c, v, dir, clamp_signal, fill, underflow_cnt, err_illegal, wr_ready,
                   m_v, m_dir, m_clamp, m_q.size(), m_under, m_err,
                   (!m_clamp && m_q.size() < DEPTH));
        end
        wr_valid = ($urandom_range(0, 99) < wr_pct[ph]);
        wr_vec   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(27, 31))
                                               : 5'($urandom_range(0, MAXV));
        wr_dir   = 3'($urandom_range(0, 7));
        gap--;
        if (gap == 0) begin
          interrupt = ~interrupt;
          gap = $urandom_range(4, 14);
        end
        cyc(1);
      end
      wr_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_illegal();
    test_underflow();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
